// File: rtl/divider_multicycle.sv
// divider_multicycle: iterative restoring divider, one quotient bit per cycle.
// Serves DIV/DIVU/REM/REMU. It produces quotient and remainder together, and
// the ALU selects between them.
// Handshake: valid is sampled only in IDLE. Once valid is accepted, busy stays
// high through RUN and DONE. done pulses for one cycle, with q/r valid in that
// cycle. q/r then hold their value until the next result replaces them.
// Latency: an operation accepted at edge N raises done after edge N+WIDTH+1.
// RUN performs WIDTH iterations. Its last cycle (count==0) applies the result
// signs and registers q/r.
// Optional feature macro: DIV_EARLY_OUT_EN. When defined, a zero divisor or
// |a| < |b| skips the iterations, and done rises after edge N+1. Results are
// identical with or without the macro.
module divider_multicycle #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic [1:0]       o_dbg_state
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_a;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_div0;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_busy;
    logic             r_done;

    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_q_fin;
    logic [WIDTH-1:0] w_r_fin;
    logic             w_early;

    // Operand magnitudes at issue time (raw values for unsigned operations)
    always_comb begin
        w_a_neg = is_signed & a[WIDTH-1];
        w_b_neg = is_signed & b[WIDTH-1];
        w_a_mag = w_a_neg ? -a : a;
        w_b_mag = w_b_neg ? -b : b;
    end

    // Early-out decision: skip the iterations when the answer is already known
    always_comb begin
`ifdef DIV_EARLY_OUT_EN
        w_early = (b == '0) || (w_a_mag < w_b_mag);
`else
        w_early = 1'b0;
`endif
    end

    // One restoring step: shift {rem, quo} left and trial-subtract the divisor.
    // Width is WIDTH+1 so that the MSB of the result is the borrow.
    always_comb begin
        w_shift = {r_rem, r_quo[WIDTH-1]};
        w_trial = w_shift - {1'b0, r_div};
    end

    // Final sign fix-up, and RISC-V divide-by-zero results (q all ones, r = a)
    always_comb begin
        w_q_fin = r_div0 ? '1  : (r_sign_q ? -r_quo : r_quo);
        w_r_fin = r_div0 ? r_a : (r_sign_r ? -r_rem : r_rem);
    end

    // Control FSM and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_a      <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_div0   <= 1'b0;
            r_q      <= '0;
            r_r      <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (valid) begin
                        r_state  <= S_RUN;
                        r_busy   <= 1'b1;
                        r_div    <= w_b_mag;
                        r_a      <= a;
                        r_div0   <= (b == '0);
                        r_sign_q <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_sign_r <= is_signed & a[WIDTH-1];
                        if (w_early) begin
                            // Quotient is zero and the remainder is |a|; go straight to fix-up
                            r_count <= '0;
                            r_quo   <= '0;
                            r_rem   <= w_a_mag;
                        end else begin
                            r_count <= CW'(WIDTH);
                            r_quo   <= w_a_mag;
                            r_rem   <= '0;
                        end
                    end
                end
                S_RUN: begin
                    if (r_count != '0) begin
                        if (!w_trial[WIDTH]) begin
                            r_rem <= w_trial[WIDTH-1:0];
                            r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                        end else begin
                            r_rem <= w_shift[WIDTH-1:0];
                            r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                        end
                        r_count <= r_count - CW'(1);
                    end else begin
                        r_q     <= w_q_fin;
                        r_r     <= w_r_fin;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign q           = r_q;
    assign r           = r_r;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_divider_multicycle.sv
// tb_divider_multicycle: checks divider_multicycle against a scoreboard of
// expected quotient, remainder and latency.
module tb_divider_multicycle;

    localparam int WIDTH = 64;

    logic             clk = 1'b0;
    logic             reset;
    logic             valid;
    logic             is_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic [1:0]       dbg_state;

    divider_multicycle #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .valid       (valid),
        .is_signed   (is_signed),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .q           (q),
        .r           (r),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset block ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] exp_r[$];
    int               exp_lat[$];
    int               acc_cyc[$];
    logic             prev_done = 1'b0;

    task automatic check_eq(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    // Reference result, computed from unsigned magnitudes
    task automatic model(input logic [WIDTH-1:0] ma_in, input logic [WIDTH-1:0] mb_in, input logic s,
                         output logic [WIDTH-1:0] eq, output logic [WIDTH-1:0] er);
        logic [WIDTH-1:0] ma, mb, uq, ur;
        if (mb_in == '0) begin
            eq = '1;
            er = ma_in;
        end else begin
            ma = (s && ma_in[WIDTH-1]) ? -ma_in : ma_in;
            mb = (s && mb_in[WIDTH-1]) ? -mb_in : mb_in;
            uq = ma / mb;
            ur = ma % mb;
            eq = (s && (ma_in[WIDTH-1] ^ mb_in[WIDTH-1])) ? -uq : uq;
            er = (s && ma_in[WIDTH-1]) ? -ur : ur;
        end
    endtask

    function automatic int exp_latency(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b, input logic s);
`ifdef DIV_EARLY_OUT_EN
        logic [WIDTH-1:0] ma, mb;
        ma = (s && op_a[WIDTH-1]) ? -op_a : op_a;
        mb = (s && op_b[WIDTH-1]) ? -op_b : op_b;
        if (op_b == '0 || ma < mb) return 1;
`endif
        return WIDTH + 1;
    endfunction

    // Output monitor: pops an expectation on each done and checks handshake shape
    always @(negedge clk) begin
        if (reset) begin
            if (prev_done) check_eq("done_pulse_width", WIDTH'(done), WIDTH'(0));
            if (exp_q.size() != 0) check_eq("busy_during_op", WIDTH'(busy), WIDTH'(1));
            if (done) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_done", WIDTH'(done), WIDTH'(0));
                end else begin
                    check_eq("result_q", q, exp_q.pop_front());
                    check_eq("result_r", r, exp_r.pop_front());
                    check_eq("latency", WIDTH'(cyc - acc_cyc.pop_front()), WIDTH'(exp_lat.pop_front()));
                end
            end
        end
        prev_done = done;
    end

    // ---------------- driver tasks ----------------
    // Hold valid through one edge while idle, record the expectation, then scramble the inputs
    task automatic start_op(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b, input logic s,
                            input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er);
        check_eq("idle_before_start", WIDTH'(busy), WIDTH'(0));
        valid     = 1'b1;
        a         = op_a;
        b         = op_b;
        is_signed = s;
        @(posedge clk);
        #1;
        exp_q.push_back(eq);
        exp_r.push_back(er);
        exp_lat.push_back(exp_latency(op_a, op_b, s));
        acc_cyc.push_back(cyc);
        valid     = 1'b0;
        a         = {$urandom, $urandom};
        b         = {$urandom, $urandom};
        is_signed = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check_eq("wait_idle_timeout", WIDTH'(ok), WIDTH'(1));
    endtask

    task automatic wait_done();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check_eq("wait_done_timeout", WIDTH'(ok), WIDTH'(1));
    endtask

    task automatic run_op(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b, input logic s,
                          input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er);
        start_op(op_a, op_b, s, eq, er);
        wait_idle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [WIDTH-1:0] ra, rb, eq, er;
        logic             rs;

        reset     = 1'b0;
        valid     = 1'b0;
        is_signed = 1'b0;
        a         = '0;
        b         = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_busy",  WIDTH'(busy), WIDTH'(0));
        check_eq("reset_done",  WIDTH'(done), WIDTH'(0));
        check_eq("reset_q",     q, WIDTH'(0));
        check_eq("reset_r",     r, WIDTH'(0));
        check_eq("reset_state", WIDTH'(dbg_state), WIDTH'(0));
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases with hand-computed results
        run_op(64'd100, 64'd7, 1'b0, 64'd14, 64'd2);
        repeat (3) @(posedge clk);
        #1;
        check_eq("hold_q", q, 64'd14);
        check_eq("hold_r", r, 64'd2);
        run_op(64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op(64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1, 64'hFFFF_FFFF_FFFF_FFF2, 64'd2);
        run_op(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'h8000_0000_0000_0000, 64'd0);
        run_op(64'h1234, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234);
        run_op(64'h1234, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd1, 64'd0);
        run_op(64'd3, 64'd10, 1'b0, 64'd0, 64'd3);
        run_op(64'hFFFF_FFFF_FFFF_FFFD, 64'd10, 1'b1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFD);

        // valid pulses and operand changes during RUN must be ignored
        start_op(64'd1000, 64'd33, 1'b0, 64'd30, 64'd10);
        repeat (10) @(posedge clk);
        #1;
        valid = 1'b1;
        a     = 64'd5;
        b     = 64'd1;
        repeat (3) @(posedge clk);
        #1;
        valid = 1'b0;
        wait_idle();

        // valid during done is ignored; it is accepted one cycle later
        start_op(64'd500, 64'd9, 1'b0, 64'd55, 64'd5);
        wait_done();
        valid     = 1'b1;
        a         = 64'd77;
        b         = 64'd5;
        is_signed = 1'b0;
        @(posedge clk);
        #1;
        check_eq("idle_one_after_done", WIDTH'(dbg_state), WIDTH'(0));
        start_op(64'd77, 64'd5, 1'b0, 64'd15, 64'd2);
        wait_idle();

        // Asynchronous reset in the middle of a division
        start_op(64'd12345, 64'd67, 1'b0, 64'd184, 64'd17);
        repeat (30) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_eq("abort_busy",  WIDTH'(busy), WIDTH'(0));
        check_eq("abort_done",  WIDTH'(done), WIDTH'(0));
        check_eq("abort_q",     q, WIDTH'(0));
        check_eq("abort_r",     r, WIDTH'(0));
        check_eq("abort_state", WIDTH'(dbg_state), WIDTH'(0));
        exp_q.delete();
        exp_r.delete();
        exp_lat.delete();
        acc_cyc.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (80) @(posedge clk);
        #1;
        check_eq("no_done_after_abort", WIDTH'(busy), WIDTH'(0));

        // Random operands against the reference model
        for (int i = 0; i < 10; i++) begin
            ra = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       rb = WIDTH'($urandom_range(1, 1000));
                1:       rb = {$urandom, $urandom};
                2:       rb = '0;
                default: rb = {32'h0, $urandom};
            endcase
            rs = 1'($urandom_range(0, 1));
            model(ra, rb, rs, eq, er);
            run_op(ra, rb, rs, eq, er);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
